wb_stage: RTL and testbench
===========================

# wb_stage

Stage-3 writeback unit of the 3-stage RV32I pipeline: the single writer of the stage-1 register file's write port. Captures stage-2 results into the stage-3 pipeline register, selects and aligns the writeback value (ALU, load data, PC+4, CSR), and drives `rd`/`wb_data`/`we`. Also supplies a forwarding path to stage 1/2 and owns the `tohost` CSR and a retired-instruction counter.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `CSR_TOHOST`, 12'h51E, CSR address of tohost

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  global pipeline stall (cache miss); 1 = hold
- `s2_valid`  in  1  stage-2 instruction valid
- `s2_rd`  in  5  destination register index
- `s2_reg_we`  in  1  instruction writes rd
- `s2_wb_sel`  in  2  writeback source: ALU / MEM / PC4 / CSR
- `s2_funct3`  in  3  load width/sign (LB, LH, LW, LBU, LHU)
- `s2_alu_out`  in  XLEN  ALU result; also load address
- `s2_pc`  in  XLEN  instruction PC
- `s2_csr_we`  in  1  CSR write (csrrw/csrrwi)
- `s2_csr_addr`  in  12  CSR address
- `s2_csr_wdata`  in  XLEN  CSR write data
- `dcache_dout`  in  XLEN  load data, valid in the cycle the load sits in stage 3 with `stall`=0
- `rd`  out  5  register-file write index
- `wb_data`  out  XLEN  register-file write data
- `we`  out  1  register-file write enable
- `fwd_valid`  out  1  stage 3 holds a pending rd write
- `fwd_rd`  out  5  forwarded index (= `rd`)
- `fwd_data`  out  XLEN  forwarded value (= `wb_data`)
- `csr_tohost`  out  XLEN  tohost register
- `instret`  out  XLEN  retired-instruction count

## Operation
- Stage-3 register (s3_*) captures all s2_* inputs on posedge when `stall`=0; holds when `stall`=1.
- `s3_valid` captures `s2_valid`; reset clears `s3_valid` only, other s3 fields don't-care.
- `we` = `s3_valid & s3_reg_we & (s3_rd != 0) & ~stall`; `rd` = `s3_rd`.
- `wb_data` by `s3_wb_sel`: ALU -> `s3_alu_out`; PC4 -> `s3_pc + 4` (mod 2^32); CSR -> `csr_tohost` if `s3_csr_addr`==CSR_TOHOST, else 0; MEM -> aligned load.
- Load align: byte offset `s3_alu_out[1:0]`; LB/LBU select byte offset*8, sign/zero-extend; LH/LHU select halfword `[1]`*16, extend; LW full word; offset bits ignored for misalignment (no trap; LH at offset 3 uses halfword 1).
- Unsupported funct3 on MEM -> `wb_data` = 0.
- CSR read returns pre-write value (csrrw semantics); tohost updates on posedge when `s3_valid & s3_csr_we & ~stall` and address matches.
- `instret` increments by 1 on posedge when `s3_valid & ~stall`; wraps 0xFFFFFFFF -> 0.
- `fwd_valid` = `s3_valid & s3_reg_we & (s3_rd != 0)` (not gated by stall); `fwd_data` is combinational, including MEM.

## Timing
- Reset values: `s3_valid`=0, `csr_tohost`=0, `instret`=0; thus `we`=0, `fwd_valid`=0 from first cycle after reset.
- Latency: instruction in stage 2 at cycle N writes regfile at posedge N+2 (captured N+1, written N+2), absent stall.
- Stall mid-load: `wb_data` tracks `dcache_dout` each cycle; write committed on first posedge with `stall`=0.
- Reset during stall: reset wins; no write, no tohost/instret update.
- rd = x0: never asserts `we` or `fwd_valid`, but CSR side effects and instret still occur.

## Structure
- Package `rv_wb_pkg`: `wb_sel_t` enum (WB_ALU=0, WB_MEM=1, WB_PC4=2, WB_CSR=3), load funct3 constants, `CSR_TOHOST` default.
- Sub-module `load_align`: combinational (funct3, offset, word) -> extended XLEN value.

## Test plan
- ALU: s2 rd=5, wb_sel=ALU, alu_out=0x1234 -> two cycles later `we`=1, `rd`=5, `wb_data`=0x1234.
- Loads: dcache_dout=0x8070F0FF; LB off 0 -> 0xFFFFFFFF; LBU off 1 -> 0xF0; LH off 2 -> 0xFFFF8070; LHU off 0 -> 0xF0FF; LW -> 0x8070F0FF.
- JAL: wb_sel=PC4, pc=0xFFFFFFFC -> `wb_data`=0x00000000 (wrap).
- CSR: csrrw tohost 0x1 with rd=3 -> `wb_data`=0 (old value), next cycle `csr_tohost`=1.
- Stall: load in stage 3, stall=1 for 3 cycles with changing dcache_dout -> `we`=0, `fwd_valid`=1 throughout; write uses value present when stall drops; `instret` +1 once.
- x0 / reset: rd=0 -> `we`=0, `fwd_valid`=0; reset asserted while s3_valid=1 -> next cycle `we`=0, `instret`=0.

Source files
------------

// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the stage-3 writeback unit.
package rv_wb_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam logic [11:0] CSR_TOHOST_DEFAULT = 12'h51E;

    // Writeback source select
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_sel_t;

    // Load width/sign encodings (funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a load word and extends it.
// Misaligned offsets are not trapped: halfwords use offset bit 1 only.
module load_align
    import rv_wb_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword lanes
    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    // Extend by load type; unsupported encodings read as zero
    always_comb begin
        value = '0;
        case (funct3)
            F3_LB:   value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   value = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  value = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   value = word;
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Stage-3 writeback: pipeline register, writeback mux, register-file
// write port, forwarding path, tohost CSR and retired-instruction counter.
module wb_stage
    import rv_wb_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEFAULT,
    parameter logic [11:0] CSR_TOHOST = CSR_TOHOST_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            s2_valid,
    input  logic [4:0]      s2_rd,
    input  logic            s2_reg_we,
    input  logic [1:0]      s2_wb_sel,
    input  logic [2:0]      s2_funct3,
    input  logic [XLEN-1:0] s2_alu_out,
    input  logic [XLEN-1:0] s2_pc,
    input  logic            s2_csr_we,
    input  logic [11:0]     s2_csr_addr,
    input  logic [XLEN-1:0] s2_csr_wdata,
    input  logic [XLEN-1:0] dcache_dout,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] wb_data,
    output logic            we,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic [XLEN-1:0] csr_tohost,
    output logic [XLEN-1:0] instret
);

    logic            s3_valid;
    logic [4:0]      s3_rd;
    logic            s3_reg_we;
    wb_sel_t         s3_wb_sel;
    logic [2:0]      s3_funct3;
    logic [XLEN-1:0] s3_alu_out;
    logic [XLEN-1:0] s3_pc;
    logic            s3_csr_we;
    logic [11:0]     s3_csr_addr;
    logic [XLEN-1:0] s3_csr_wdata;

    logic [XLEN-1:0] load_value;
    logic            csr_hit;
    logic            retire;

    assign csr_hit = (s3_csr_addr == CSR_TOHOST);
    assign retire  = s3_valid & ~stall;

    // Stage-3 valid bit: the only field cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            s3_valid <= 1'b0;
        end else if (!stall) begin
            s3_valid <= s2_valid;
        end
    end

    // Stage-3 payload: meaningful only while s3_valid is set
    always_ff @(posedge clk) begin
        if (!stall) begin
            s3_rd        <= s2_rd;
            s3_reg_we    <= s2_reg_we;
            s3_wb_sel    <= wb_sel_t'(s2_wb_sel);
            s3_funct3    <= s2_funct3;
            s3_alu_out   <= s2_alu_out;
            s3_pc        <= s2_pc;
            s3_csr_we    <= s2_csr_we;
            s3_csr_addr  <= s2_csr_addr;
            s3_csr_wdata <= s2_csr_wdata;
        end
    end

    // tohost is written as the csrrw retires; the read above sees the old value
    always_ff @(posedge clk) begin
        if (reset) begin
            csr_tohost <= '0;
        end else if (retire && s3_csr_we && csr_hit) begin
            csr_tohost <= s3_csr_wdata;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + XLEN'(1);
        end
    end

    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .funct3 (s3_funct3),
        .offset (s3_alu_out[1:0]),
        .word   (dcache_dout),
        .value  (load_value)
    );

    // Writeback value select; load data follows dcache_dout while stalled
    always_comb begin
        wb_data = '0;
        case (s3_wb_sel)
            WB_ALU: wb_data = s3_alu_out;
            WB_MEM: wb_data = load_value;
            WB_PC4: wb_data = s3_pc + XLEN'(4);
            WB_CSR: wb_data = csr_hit ? csr_tohost : '0;
        endcase
    end

    assign fwd_valid = s3_valid & s3_reg_we & (s3_rd != 5'd0);
    assign we        = fwd_valid & ~stall;
    assign rd        = s3_rd;
    assign fwd_rd    = s3_rd;
    assign fwd_data  = wb_data;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized scoreboard bench for wb_stage against a sequential ISA-level model.
module tb_wb_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        s2_valid;
    logic [4:0]  s2_rd;
    logic        s2_reg_we;
    logic [1:0]  s2_wb_sel;
    logic [2:0]  s2_funct3;
    logic [31:0] s2_alu_out;
    logic [31:0] s2_pc;
    logic        s2_csr_we;
    logic [11:0] s2_csr_addr;
    logic [31:0] s2_csr_wdata;
    logic [31:0] dcache_dout;
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic        we;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [31:0] csr_tohost;
    logic [31:0] instret;

    wb_stage #(
        .XLEN       (32),
        .CSR_TOHOST (12'h51E)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .s2_valid     (s2_valid),
        .s2_rd        (s2_rd),
        .s2_reg_we    (s2_reg_we),
        .s2_wb_sel    (s2_wb_sel),
        .s2_funct3    (s2_funct3),
        .s2_alu_out   (s2_alu_out),
        .s2_pc        (s2_pc),
        .s2_csr_we    (s2_csr_we),
        .s2_csr_addr  (s2_csr_addr),
        .s2_csr_wdata (s2_csr_wdata),
        .dcache_dout  (dcache_dout),
        .rd           (rd),
        .wb_data      (wb_data),
        .we           (we),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
        .csr_tohost   (csr_tohost),
        .instret      (instret)
    );

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        reg_we;
        logic [1:0]  wb_sel;
        logic [2:0]  funct3;
        logic [31:0] alu_out;
        logic [31:0] pc;
        logic        csr_we;
        logic [11:0] csr_addr;
        logic [31:0] csr_wdata;
        logic [31:0] ld_word;
    } ins_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    ins_t        s3m;
    logic [31:0] tohost_m;
    logic [31:0] tohost_seq;
    logic [31:0] instret_m;
    int          n_checks = 0;
    int          n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Architectural result of one instruction, from the ISA rules
    function automatic logic [31:0] ref_val(input ins_t i, input logic [31:0] th, input logic [31:0] word);
        int unsigned off;
        logic [31:0] b;
        logic [31:0] h;
        off = i.alu_out % 4;
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * (off / 2))) & 32'hFFFF;
        case (i.wb_sel)
            2'd0: return i.alu_out;
            2'd2: return i.pc + 32'd4;
            2'd3: return (i.csr_addr == 12'h51E) ? th : 32'd0;
            default: begin
                case (i.funct3)
                    3'd0: return (b >= 32'd128) ? b - 32'd256 : b;
                    3'd4: return b;
                    3'd1: return (h >= 32'd32768) ? h - 32'd65536 : h;
                    3'd5: return h;
                    3'd2: return word;
                    default: return 32'd0;
                endcase
            end
        endcase
    endfunction

    function automatic ins_t mk(input logic [4:0] r, input logic [1:0] sel, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] pc, input logic cwe,
                                input logic [11:0] caddr, input logic [31:0] cwd, input logic [31:0] word);
        ins_t i;
        i.valid = 1'b1; i.rd = r; i.reg_we = 1'b1; i.wb_sel = sel; i.funct3 = f3;
        i.alu_out = alu; i.pc = pc; i.csr_we = cwe; i.csr_addr = caddr;
        i.csr_wdata = cwd; i.ld_word = word;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        logic [2:0] f3s [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};
        i.valid     = ($urandom_range(0, 9) != 0);
        i.rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        i.reg_we    = ($urandom_range(0, 5) != 0);
        i.wb_sel    = 2'($urandom);
        i.funct3    = f3s[$urandom_range(0, 6)];
        i.alu_out   = $urandom;
        i.pc        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
        i.csr_we    = ($urandom_range(0, 2) == 0);
        i.csr_addr  = ($urandom_range(0, 1) == 0) ? 12'h51E : 12'($urandom);
        i.csr_wdata = $urandom;
        i.ld_word   = $urandom;
        return i;
    endfunction

    // One clock: drive, check stage-3 visible state, then advance the model
    task automatic step(input logic st, input logic rst, input ins_t ins,
                        input logic ovr, input logic [31:0] ovr_val);
        logic [31:0] dword;
        logic [31:0] e;
        logic        pend;
        reset = rst; stall = st;
        s2_valid = ins.valid; s2_rd = ins.rd; s2_reg_we = ins.reg_we;
        s2_wb_sel = ins.wb_sel; s2_funct3 = ins.funct3; s2_alu_out = ins.alu_out;
        s2_pc = ins.pc; s2_csr_we = ins.csr_we; s2_csr_addr = ins.csr_addr;
        s2_csr_wdata = ins.csr_wdata;
        if (s3m.valid && s3m.wb_sel == 2'd1 && !st) dword = s3m.ld_word;
        else dword = $urandom;
        dcache_dout = dword;
        @(negedge clk);
        pend = s3m.valid && s3m.reg_we && (s3m.rd != 5'd0);
        chk("fwd_valid", 32'(fwd_valid), 32'(pend));
        if (pend) begin
            chk("fwd_rd", 32'(fwd_rd), 32'(s3m.rd));
            chk("rd", 32'(rd), 32'(s3m.rd));
            chk("fwd_data", fwd_data, ref_val(s3m, tohost_m, dword));
        end
        chk("csr_tohost", csr_tohost, tohost_m);
        chk("instret", instret, instret_m);
        @(posedge clk);
        #1;
        if (rst) begin
            s3m = '0; tohost_m = '0; tohost_seq = '0; instret_m = '0;
            q.delete();
        end else if (!st) begin
            if (s3m.valid) begin
                instret_m = instret_m + 32'd1;
                if (s3m.csr_we && s3m.csr_addr == 12'h51E) tohost_m = s3m.csr_wdata;
            end
            s3m = ins;
            if (ins.valid) begin
                e = ovr ? ovr_val : ref_val(ins, tohost_seq, ins.ld_word);
                if (ins.reg_we && ins.rd != 5'd0) q.push_back('{rd: ins.rd, data: e});
                if (ins.csr_we && ins.csr_addr == 12'h51E) tohost_seq = ins.csr_wdata;
            end
        end
    endtask

    // Write-port monitor: every register-file write must match the next expectation
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_write: got we=1 rd=%0d data=%h expected no write at %0t",
                         rd, wb_data, $time);
            end else begin
                exp_t x;
                x = q.pop_front();
                chk("wb_rd", 32'(rd), 32'(x.rd));
                chk("wb_data", wb_data, x.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        ins_t bub;
        ins_t cur;
        logic accepted;
        logic [2:0]  lf3 [7] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd1, 3'd3};
        logic [1:0]  loff[7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd3, 2'd0};
        logic [31:0] lexp[7] = '{32'hFFFF_FFFF, 32'h0000_00F0, 32'hFFFF_8070, 32'h0000_F0FF,
                                 32'h8070_F0FF, 32'hFFFF_8070, 32'h0000_0000};
        bub = '0;
        s3m = '0; tohost_m = '0; tohost_seq = '0; instret_m = '0;
        reset = 1'b1; stall = 1'b0; dcache_dout = '0;
        s2_valid = 1'b0; s2_rd = '0; s2_reg_we = 1'b0; s2_wb_sel = '0; s2_funct3 = '0;
        s2_alu_out = '0; s2_pc = '0; s2_csr_we = 1'b0; s2_csr_addr = '0; s2_csr_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we", 32'(we), 32'd0);

        // ALU result
        step(0, 0, mk(5'd5, 2'd0, 3'd0, 32'h1234, 32'h0, 0, 12'h0, 32'h0, 32'h0), 1, 32'h1234);
        // Load alignment/extension table
        for (int k = 0; k < 7; k++)
            step(0, 0, mk(5'(k + 1), 2'd1, lf3[k], 32'h1000 | 32'(loff[k]), 32'h0, 0, 12'h0,
                          32'h0, 32'h8070_F0FF), 1, lexp[k]);
        // PC+4 wrap
        step(0, 0, mk(5'd6, 2'd2, 3'd0, 32'h0, 32'hFFFF_FFFC, 0, 12'h0, 32'h0, 32'h0), 1, 32'h0);
        // csrrw tohost returns old value, later read sees new one, other CSR reads zero
        step(0, 0, mk(5'd3, 2'd3, 3'd0, 32'h0, 32'h0, 1, 12'h51E, 32'h1, 32'h0), 1, 32'h0);
        step(0, 0, mk(5'd4, 2'd3, 3'd0, 32'h0, 32'h0, 0, 12'h51E, 32'h0, 32'h0), 1, 32'h1);
        step(0, 0, mk(5'd8, 2'd3, 3'd0, 32'h0, 32'h0, 0, 12'h300, 32'h0, 32'h0), 1, 32'h0);
        // Load held in stage 3 across a 3-cycle stall
        step(0, 0, mk(5'd9, 2'd1, 3'd4, 32'h2002, 32'h0, 0, 12'h0, 32'h0, 32'h11AA_2233), 1, 32'hAA);
        cur = mk(5'd10, 2'd0, 3'd0, 32'hDEAD_0001, 32'h0, 0, 12'h0, 32'h0, 32'h0);
        repeat (3) step(1, 0, cur, 1, 32'hDEAD_0001);
        step(0, 0, cur, 1, 32'hDEAD_0001);
        // x0 destination: no write, still retires
        step(0, 0, mk(5'd0, 2'd0, 3'd0, 32'h5555, 32'h0, 0, 12'h0, 32'h0, 32'h0), 0, 32'h0);
        step(0, 0, bub, 0, 32'h0);
        step(0, 0, bub, 0, 32'h0);

        // Randomized stream with random stalls
        accepted = 1'b1;
        cur = bub;
        for (int n = 0; n < 1500; n++) begin
            logic st;
            if (accepted) cur = rand_ins();
            st = ($urandom_range(0, 3) == 0);
            step(st, 0, cur, 0, 32'h0);
            accepted = !st;
        end
        step(0, 0, bub, 0, 32'h0);
        step(0, 0, bub, 0, 32'h0);

        // Reset during stall with a pending tohost write in stage 3
        step(0, 0, mk(5'd7, 2'd3, 3'd0, 32'h0, 32'h0, 1, 12'h51E, 32'hAB, 32'h0), 0, 32'h0);
        step(1, 1, bub, 0, 32'h0);
        step(0, 0, bub, 0, 32'h0);
        step(0, 0, bub, 0, 32'h0);

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
